// File: rtl/mem_1r1w_masked_init.sv
// Parametrised single-clock 1R1W memory with per-lane write mask.
// It has an optional same-cycle write-to-read bypass and a read latency of 1 or 2.
// After every reset, a clear sequencer zeroes each entry before user traffic is accepted.
module mem_1r1w_masked_init #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 64,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  parameter int ADDR_W       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  parameter int MASK_W       = WIDTH / MASK_GRAN
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0]  ZERO_W = {WIDTH{1'b0}};

  if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
    $error("mem_1r1w_masked_init: WIDTH must be a multiple of MASK_GRAN");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_lat
    $error("mem_1r1w_masked_init: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("mem_1r1w_masked_init: DEPTH must be at least 2");
  end

  // Lanes selected by mask take the new word; the others keep the old word.
  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0]  old_w,
                                                   input logic [WIDTH-1:0]  new_w,
                                                   input logic [MASK_W-1:0] mask);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        res[i*MASK_GRAN +: MASK_GRAN] = new_w[i*MASK_GRAN +: MASK_GRAN];
      end else begin
        res[i*MASK_GRAN +: MASK_GRAN] = old_w[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    return res;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
  logic              init_busy_r;
  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [WIDTH-1:0]  wr_data_s;
  logic [MASK_W-1:0] wr_mask_s;
  logic              w_in_range_s, r_in_range_s;
  logic              rd_hit_s;
  logic [WIDTH-1:0]  rd_word_s;
  logic              out_v_s;
  logic [WIDTH-1:0]  out_d_s;
  logic              r0_valid_r;
  logic [WIDTH-1:0]  r0_data_r;

  // Addresses past DEPTH can only occur when DEPTH is not a power of two.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign w_in_range_s = 1'b1;
    assign r_in_range_s = 1'b1;
  end else begin : g_npow2
    assign w_in_range_s = (W0_addr <= LAST_A);
    assign r_in_range_s = (R0_addr <= LAST_A);
  end

  // Next state, and selection of the single write port: the clear sweep or the user.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = W0_addr;
    wr_data_s   = W0_data;
    wr_mask_s   = W0_mask;
    case (state_r)
      ST_INIT: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_r;
        wr_data_s = ZERO_W;
        wr_mask_s = {MASK_W{1'b1}};
        if (cnt_r == LAST_A) begin
          state_nxt_s = ST_READY;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        wr_en_s = W0_en & w_in_range_s;
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, clear counter and busy flag; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      init_busy_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      init_busy_r <= (state_nxt_s == ST_INIT);
    end
  end

  // Storage array; reset does not touch it, and the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= merge_lanes(mem_r[wr_addr_s], wr_data_s, wr_mask_s);
    end
  end

  assign rd_hit_s = (state_r == ST_READY) & R0_en;

  // Sample the array and optionally forward lanes written in the same cycle.
  always_comb begin
    rd_word_s = ZERO_W;
    if (!r_in_range_s) begin
      rd_word_s = ZERO_W;
    end else if ((BYPASS != 0) && W0_en && (W0_addr == R0_addr)) begin
      rd_word_s = merge_lanes(mem_r[R0_addr], W0_data, W0_mask);
    end else begin
      rd_word_s = mem_r[R0_addr];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             p1_valid_r;
    logic [WIDTH-1:0] p1_data_r;

    // The extra stage is a pure register and does not see later writes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p1_valid_r <= 1'b0;
        p1_data_r  <= ZERO_W;
      end else begin
        p1_valid_r <= rd_hit_s;
        if (rd_hit_s) begin
          p1_data_r <= rd_word_s;
        end else begin
          p1_data_r <= p1_data_r;
        end
      end
    end

    assign out_v_s = p1_valid_r;
    assign out_d_s = p1_data_r;
  end else begin : g_lat1
    assign out_v_s = rd_hit_s;
    assign out_d_s = rd_word_s;
  end

  // Output stage: data holds between reads, and valid is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_valid_r <= 1'b0;
      r0_data_r  <= ZERO_W;
    end else begin
      r0_valid_r <= out_v_s;
      if (out_v_s) begin
        r0_data_r <= out_d_s;
      end else begin
        r0_data_r <= r0_data_r;
      end
    end
  end

  assign init_busy = init_busy_r;
  assign R0_valid  = r0_valid_r;
  assign R0_data   = r0_data_r;

endmodule

// File: tb/tb_mem_1r1w_masked_init.sv
// Bench for mem_1r1w_masked_init.
// Instance a: DEPTH=32, latency 1, bypass on.
// Instance b: DEPTH=20, latency 2, bypass off.
// Each instance is checked against a word-array reference model.
module tb_mem_1r1w_masked_init;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]  a_raddr, a_waddr, b_raddr, b_waddr;
  logic        a_ren, a_wen, b_ren, b_wen;
  logic [63:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [7:0]  a_wmask, b_wmask;
  logic        a_rvalid, b_rvalid, a_busy, b_busy;

  mem_1r1w_masked_init #(.DEPTH(32), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .init_busy(a_busy),
    .R0_addr(a_raddr), .R0_en(a_ren), .R0_data(a_rdata), .R0_valid(a_rvalid),
    .W0_addr(a_waddr), .W0_en(a_wen), .W0_data(a_wdata), .W0_mask(a_wmask));

  mem_1r1w_masked_init #(.DEPTH(20), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(2), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .init_busy(b_busy),
    .R0_addr(b_raddr), .R0_en(b_ren), .R0_data(b_rdata), .R0_valid(b_rvalid),
    .W0_addr(b_waddr), .W0_en(b_wen), .W0_data(b_wdata), .W0_mask(b_wmask));

  int n_run = 0;
  int n_fail = 0;

  // reference model
  logic [63:0] ma [32];
  logic [63:0] mb [20];
  logic        ea_v, eb_v, pb_v;
  logic [63:0] ea_d, eb_d, pb_d;

  function automatic logic [63:0] lane_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                             input logic [7:0] mask);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < 8; i++) if (mask[i]) m = m | (64'hFF << (8 * i));
    return (old_w & ~m) | (new_w & m);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ma[i] = 64'd0;
    for (int i = 0; i < 20; i++) mb[i] = 64'd0;
    ea_v = 1'b0; eb_v = 1'b0; pb_v = 1'b0;
    ea_d = 64'd0; eb_d = 64'd0; pb_d = 64'd0;
  endtask

  task automatic idle_inputs();
    a_ren = 1'b0; a_wen = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
    a_raddr = 5'd0; a_waddr = 5'd0; b_raddr = 5'd0; b_waddr = 5'd0;
    a_wdata = 64'd0; b_wdata = 64'd0; a_wmask = 8'd0; b_wmask = 8'd0;
  endtask

  // Update the model from the driven inputs, advance one clock, and return at the negedge.
  task automatic tick();
    logic [63:0] ra, rb;
    ra = ma[a_raddr];
    if (a_wen && a_waddr == a_raddr) ra = lane_merge(ra, a_wdata, a_wmask);
    if (a_wen) ma[a_waddr] = lane_merge(ma[a_waddr], a_wdata, a_wmask);
    ea_v = a_ren;
    if (a_ren) ea_d = ra;
    rb = (b_raddr < 5'd20) ? mb[b_raddr] : 64'd0;
    if (b_wen && b_waddr < 5'd20) mb[b_waddr] = lane_merge(mb[b_waddr], b_wdata, b_wmask);
    eb_v = pb_v;
    if (pb_v) eb_d = pb_d;
    pb_v = b_ren;
    pb_d = rb;
    @(posedge clk);
    @(negedge clk);
    a_ren = 1'b0; a_wen = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
  endtask

  // Release reset and count the cycles each instance stays busy while user traffic is offered.
  task automatic run_init(output int na, output int nb, output int nbad);
    na = -1; nb = -1; nbad = 0;
    rst_n = 1'b1;
    for (int c = 1; c <= 200 && (na < 0 || nb < 0); c++) begin
      a_wen = a_busy; a_ren = a_busy; b_wen = b_busy; b_ren = b_busy;
      a_waddr = 5'($urandom_range(31, 0)); a_raddr = 5'($urandom_range(31, 0));
      b_waddr = 5'($urandom_range(19, 0)); b_raddr = 5'($urandom_range(19, 0));
      a_wdata = {$urandom(), $urandom()}; b_wdata = {$urandom(), $urandom()};
      a_wmask = 8'hFF; b_wmask = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      if (a_rvalid || b_rvalid || a_rdata !== 64'd0 || b_rdata !== 64'd0) nbad++;
      if (!a_busy && na < 0) na = c;
      if (!b_busy && nb < 0) nb = c;
    end
    idle_inputs();
    model_clear();
  endtask

  task automatic test_reset();
    int na, nb, nbad;
    n_run++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 ||
        a_rdata !== 64'd0 || b_rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b/%b valid=%b/%b data=%h/%h, required busy=1/1 valid=0/0 data=0/0",
               a_busy, b_busy, a_rvalid, b_rvalid, a_rdata, b_rdata);
    end
    run_init(na, nb, nbad);
    n_run++;
    if (na != 32) begin n_fail++; $display("FAIL init_len_a: got %0d cycles, required 32", na); end
    n_run++;
    if (nb != 20) begin n_fail++; $display("FAIL init_len_b: got %0d cycles, required 20", nb); end
    n_run++;
    if (nbad != 0) begin n_fail++; $display("FAIL init_quiet: %0d cycles with valid/data activity, required 0", nbad); end
  endtask

  task automatic test_init_reads();
    for (int i = 0; i < 33; i++) begin
      if (i < 32) begin a_ren = 1'b1; a_raddr = 5'(i); end
      if (i < 20) begin b_ren = 1'b1; b_raddr = 5'(i); end
      tick();
      n_run++;
      if (a_rvalid !== ea_v || a_rdata !== ea_d || (i < 32 && a_rdata !== 64'd0)) begin
        n_fail++;
        $display("FAIL init_read_a[%0d]: got v=%b d=%h, required v=%b d=%h", i, a_rvalid, a_rdata, ea_v, ea_d);
      end
      n_run++;
      if (b_rvalid !== eb_v || b_rdata !== eb_d) begin
        n_fail++;
        $display("FAIL init_read_b[%0d]: got v=%b d=%h, required v=%b d=%h", i, b_rvalid, b_rdata, eb_v, eb_d);
      end
    end
  endtask

  task automatic test_masked_write();
    a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 64'h1122334455667788; a_wmask = 8'hFF; tick();
    a_wen = 1'b1; a_waddr = 5'd5; a_wdata = 64'hAAAAAAAAAAAAAAAA; a_wmask = 8'h0F; tick();
    a_ren = 1'b1; a_raddr = 5'd5; tick();
    n_run++;
    if (a_rvalid !== 1'b1 || a_rdata !== 64'h11223344AAAAAAAA) begin
      n_fail++;
      $display("FAIL masked_write: got v=%b d=%h, required v=1 d=11223344aaaaaaaa", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_bypass();
    a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 64'd0; a_wmask = 8'hFF;
    b_wen = 1'b1; b_waddr = 5'd9; b_wdata = 64'd0; b_wmask = 8'hFF;
    tick();
    a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 64'hFFFFFFFFFFFFFFFF; a_wmask = 8'h01; a_ren = 1'b1; a_raddr = 5'd9;
    b_wen = 1'b1; b_waddr = 5'd9; b_wdata = 64'hFFFFFFFFFFFFFFFF; b_wmask = 8'h01; b_ren = 1'b1; b_raddr = 5'd9;
    tick();
    n_run++;
    if (a_rvalid !== 1'b1 || a_rdata !== 64'h00000000000000FF) begin
      n_fail++; $display("FAIL bypass_on: got v=%b d=%h, required v=1 d=00000000000000ff", a_rvalid, a_rdata);
    end
    tick();
    n_run++;
    if (b_rvalid !== 1'b1 || b_rdata !== 64'd0) begin
      n_fail++; $display("FAIL bypass_off: got v=%b d=%h, required v=1 d=0", b_rvalid, b_rdata);
    end
    a_ren = 1'b1; a_raddr = 5'd9; b_ren = 1'b1; b_raddr = 5'd9;
    tick();
    n_run++;
    if (a_rvalid !== 1'b1 || a_rdata !== 64'hFF) begin
      n_fail++; $display("FAIL bypass_reread_a: got v=%b d=%h, required v=1 d=ff", a_rvalid, a_rdata);
    end
    tick();
    n_run++;
    if (b_rvalid !== 1'b1 || b_rdata !== 64'hFF) begin
      n_fail++; $display("FAIL bypass_reread_b: got v=%b d=%h, required v=1 d=ff", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_latency2();
    logic [63:0] want [4];
    logic        want_v [4];
    want[0] = 64'h0; want[1] = 64'h10; want[2] = 64'h20; want[3] = 64'h30;
    want_v[0] = 1'b0; want_v[1] = 1'b1; want_v[2] = 1'b1; want_v[3] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b_wen = 1'b1; b_waddr = 5'(i); b_wdata = 64'(i * 16); b_wmask = 8'hFF; tick();
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin b_ren = 1'b1; b_raddr = 5'(c + 1); end
      if (c == 1) begin b_wen = 1'b1; b_waddr = 5'd1; b_wdata = 64'h99; b_wmask = 8'hFF; end
      tick();
      n_run++;
      if (b_rvalid !== want_v[c] || (want_v[c] && b_rdata !== want[c])) begin
        n_fail++;
        $display("FAIL latency2[%0d]: got v=%b d=%h, required v=%b d=%h", c, b_rvalid, b_rdata, want_v[c], want[c]);
      end
    end
    tick();
    n_run++;
    if (b_rvalid !== 1'b0 || b_rdata !== 64'h30) begin
      n_fail++; $display("FAIL latency2_hold: got v=%b d=%h, required v=0 d=30", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_out_of_range();
    b_wen = 1'b1; b_waddr = 5'd25; b_wdata = 64'h1234; b_wmask = 8'hFF; tick();
    b_ren = 1'b1; b_raddr = 5'd25; tick();
    tick();
    n_run++;
    if (b_rvalid !== 1'b1 || b_rdata !== 64'd0) begin
      n_fail++; $display("FAIL oor_read: got v=%b d=%h, required v=1 d=0", b_rvalid, b_rdata);
    end
    b_wen = 1'b1; b_waddr = 5'd19; b_wdata = 64'h55; b_wmask = 8'hFF; tick();
    b_ren = 1'b1; b_raddr = 5'd19; tick();
    tick();
    n_run++;
    if (b_rvalid !== 1'b1 || b_rdata !== 64'h55) begin
      n_fail++; $display("FAIL last_entry: got v=%b d=%h, required v=1 d=55", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      a_wen = 1'($urandom_range(1, 0)); a_waddr = 5'($urandom_range(31, 0));
      a_wdata = {$urandom(), $urandom()}; a_wmask = 8'($urandom());
      a_ren = ($urandom_range(3, 0) != 0);
      a_raddr = ($urandom_range(2, 0) == 0) ? a_waddr : 5'($urandom_range(31, 0));
      b_wen = 1'($urandom_range(1, 0)); b_waddr = 5'($urandom_range(31, 0));
      b_wdata = {$urandom(), $urandom()}; b_wmask = 8'($urandom());
      b_ren = ($urandom_range(3, 0) != 0);
      b_raddr = ($urandom_range(2, 0) == 0) ? b_waddr : 5'($urandom_range(31, 0));
      tick();
      n_run++;
      if (a_rvalid !== ea_v || a_rdata !== ea_d) begin
        n_fail++; $display("FAIL random_a[%0d]: got v=%b d=%h, required v=%b d=%h", i, a_rvalid, a_rdata, ea_v, ea_d);
      end
      n_run++;
      if (b_rvalid !== eb_v || b_rdata !== eb_d) begin
        n_fail++; $display("FAIL random_b[%0d]: got v=%b d=%h, required v=%b d=%h", i, b_rvalid, b_rdata, eb_v, eb_d);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int na, nb, nbad, nv;
    a_wen = 1'b1; a_waddr = 5'd3; a_wdata = 64'hDEAD; a_wmask = 8'hFF;
    b_wen = 1'b1; b_waddr = 5'd3; b_wdata = 64'hDEAD; b_wmask = 8'hFF;
    tick();
    a_ren = 1'b1; a_raddr = 5'd3; b_ren = 1'b1; b_raddr = 5'd3; tick();
    tick();
    n_run++;
    if (a_rdata !== 64'hDEAD || b_rdata !== 64'hDEAD) begin
      n_fail++; $display("FAIL pre_reset_data: got %h/%h, required dead/dead", a_rdata, b_rdata);
    end
    b_ren = 1'b1; b_raddr = 5'd3; tick();
    a_ren = 1'b1; a_raddr = 5'd3;
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 64'd0 || b_rdata !== 64'd0 ||
        a_busy !== 1'b1 || b_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b/%b data=%h/%h busy=%b/%b, required 0/0 0/0 1/1",
               a_rvalid, b_rvalid, a_rdata, b_rdata, a_busy, b_busy);
    end
    nv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (a_rvalid || b_rvalid) nv++;
    end
    n_run++;
    if (nv != 0) begin n_fail++; $display("FAIL reset_discard: %0d valid pulses, required 0", nv); end
    run_init(na, nb, nbad);
    n_run++;
    if (na != 32 || nb != 20 || nbad != 0) begin
      n_fail++; $display("FAIL reinit: got %0d/%0d cycles %0d active, required 32/20 0", na, nb, nbad);
    end
    a_ren = 1'b1; a_raddr = 5'd3; b_ren = 1'b1; b_raddr = 5'd3; tick();
    n_run++;
    if (a_rvalid !== 1'b1 || a_rdata !== 64'd0) begin
      n_fail++; $display("FAIL reinit_read_a: got v=%b d=%h, required v=1 d=0", a_rvalid, a_rdata);
    end
    tick();
    n_run++;
    if (b_rvalid !== 1'b1 || b_rdata !== 64'd0) begin
      n_fail++; $display("FAIL reinit_read_b: got v=%b d=%h, required v=1 d=0", b_rvalid, b_rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_init_reads();
    test_masked_write();
    test_bypass();
    test_latency2();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
